// File: rtl/mem_access_stage.sv
// Memory-stage access controller: request/grant/response handshake with data memory,
// store lane formatting, load extension and pipeline stall generation.
module mem_access_stage #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ValidM,
  input  logic                  MemReadM,
  input  logic                  MemWriteM,
  input  logic [2:0]            Funct3M,
  input  logic [DATA_WIDTH-1:0] ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  output logic                  DReq,
  output logic                  DWe,
  output logic [DATA_WIDTH-1:0] DAddr,
  output logic [3:0]            DByteEn,
  output logic [DATA_WIDTH-1:0] DWData,
  input  logic                  DGnt,
  input  logic                  DRValid,
  input  logic [DATA_WIDTH-1:0] DRData,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallM,
  output logic                  FaultM
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitR, StDone} state_e;

  state_e      state;
  logic [1:0]  lane;
  logic [2:0]  op_funct3;

  logic        mem_op;
  logic        rw_both;
  logic        bad_funct3;
  logic        misaligned;
  logic        fault;
  logic        start;
  logic [1:0]  addr_lane;
  logic [3:0]  st_byte_en;
  logic [DATA_WIDTH-1:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [DATA_WIDTH-1:0] ld_ext;

  assign addr_lane = ALUResultM[1:0];
  assign mem_op    = ValidM & (MemReadM ^ MemWriteM);
  assign rw_both   = ValidM & MemReadM & MemWriteM;

  always_comb begin
    bad_funct3 = 1'b1;
    unique case (Funct3M)
      3'b000, 3'b001, 3'b010: bad_funct3 = 1'b0;
      3'b100, 3'b101:         bad_funct3 = MemWriteM;
      default:                bad_funct3 = 1'b1;
    endcase
  end

  assign misaligned = ((Funct3M[1:0] == 2'b01) & addr_lane[0]) |
                      ((Funct3M[1:0] == 2'b10) & (addr_lane != 2'b00));

  // Faults and new requests are only evaluated in IDLE; later states work from latched copies.
  assign fault  = (state == StIdle) & (rw_both | (mem_op & (bad_funct3 | misaligned)));
  assign start  = (state == StIdle) & mem_op & ~fault;
  assign FaultM = fault;
  assign StallM = start | (state == StReq) | (state == StWaitR);

  always_comb begin
    st_byte_en = 4'b1111;
    st_wdata   = WriteDataM;
    unique case (Funct3M[1:0])
      2'b00: begin
        st_byte_en = 4'b0001 << addr_lane;
        st_wdata   = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        st_byte_en = addr_lane[1] ? 4'b1100 : 4'b0011;
        st_wdata   = {2{WriteDataM[15:0]}};
      end
      default: begin
        st_byte_en = 4'b1111;
        st_wdata   = WriteDataM;
      end
    endcase
  end

  always_comb begin
    ld_byte = DRData[7:0];
    unique case (lane)
      2'd0: ld_byte = DRData[7:0];
      2'd1: ld_byte = DRData[15:8];
      2'd2: ld_byte = DRData[23:16];
      2'd3: ld_byte = DRData[31:24];
      default: ld_byte = DRData[7:0];
    endcase
  end

  assign ld_half = lane[1] ? DRData[31:16] : DRData[15:0];

  always_comb begin
    ld_ext = DRData;
    unique case (op_funct3)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = DRData;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      DReq      <= 1'b0;
      DWe       <= 1'b0;
      DAddr     <= '0;
      DByteEn   <= 4'b0000;
      DWData    <= '0;
      ReadDataM <= '0;
      lane      <= 2'b00;
      op_funct3 <= 3'b000;
    end else begin
      unique case (state)
        StIdle: begin
          if (fault) begin
            ReadDataM <= '0;
          end else if (start) begin
            DAddr     <= {ALUResultM[DATA_WIDTH-1:2], 2'b00};
            DWe       <= MemWriteM;
            DByteEn   <= st_byte_en;
            DWData    <= st_wdata;
            lane      <= addr_lane;
            op_funct3 <= Funct3M;
            DReq      <= 1'b1;
            state     <= StReq;
          end
        end
        StReq: begin
          if (DGnt) begin
            DReq  <= 1'b0;
            DWe   <= 1'b0;
            state <= DWe ? StDone : StWaitR;
          end
        end
        StWaitR: begin
          if (DRValid) begin
            ReadDataM <= ld_ext;
            state     <= StDone;
          end
        end
        StDone:  state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed, table-driven bench for mem_access_stage with a small reactive memory responder.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidM, MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        DReq, DWe;
  logic [31:0] DAddr;
  logic [3:0]  DByteEn;
  logic [31:0] DWData;
  logic        DGnt, DRValid;
  logic [31:0] DRData;
  logic [31:0] ReadDataM;
  logic        StallM, FaultM;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .ValidM(ValidM), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DByteEn(DByteEn), .DWData(DWData),
    .DGnt(DGnt), .DRValid(DRValid), .DRData(DRData), .ReadDataM(ReadDataM),
    .StallM(StallM), .FaultM(FaultM)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdin;
    int          gnt_dly;
    int          rv_dly;
    logic        exp_fault;
    int          exp_stalls;
    logic [31:0] exp_daddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [0:14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ValidM = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
    Funct3M = 3'b000; ALUResultM = '0; WriteDataM = '0;
    DGnt = 1'b0; DRValid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int  stalls, req_cnt, wait_cnt;
    bit  seen, granted, done;
    @(negedge clk);
    ValidM = v.valid; MemReadM = v.rd; MemWriteM = v.wr; Funct3M = v.f3;
    ALUResultM = v.addr; WriteDataM = v.wd; DRData = v.rdin;
    DGnt = 1'b0; DRValid = 1'b0;
    #1;
    chk({v.name, " fault"}, 32'(FaultM), 32'(v.exp_fault));
    if (v.exp_stalls == 0) begin
      chk({v.name, " stall"}, 32'(StallM), 32'd0);
      @(posedge clk); #1;
      chk({v.name, " no req"}, 32'(DReq), 32'd0);
      chk({v.name, " rdata"}, ReadDataM, v.exp_rdata);
      clear_inputs();
    end else begin
      stalls = StallM ? 1 : 0;
      seen = 0; granted = 0; done = 0; req_cnt = 0; wait_cnt = 0;
      for (int i = 0; i < 40 && !done; i++) begin
        @(posedge clk);
        @(negedge clk);
        DGnt = 1'b0; DRValid = 1'b0;
        if (DReq) begin
          if (!seen) begin
            seen = 1;
            chk({v.name, " daddr"}, DAddr, v.exp_daddr);
            chk({v.name, " byte_en"}, 32'(DByteEn), 32'(v.exp_be));
            chk({v.name, " wdata"}, DWData, v.exp_wdata);
            chk({v.name, " we"}, 32'(DWe), 32'(v.wr));
          end
          if (req_cnt == v.gnt_dly) begin
            DGnt = 1'b1;
            granted = 1;
          end
          req_cnt++;
        end else if (granted && v.rd) begin
          if (wait_cnt == v.rv_dly) DRValid = 1'b1;
          wait_cnt++;
        end
        #1;
        if (StallM) stalls++;
        else done = 1;
      end
      chk({v.name, " stall cycles"}, 32'(stalls), 32'(v.exp_stalls));
      chk({v.name, " req dropped"}, 32'(DReq), 32'd0);
      chk({v.name, " rdata"}, ReadDataM, v.exp_rdata);
      clear_inputs();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t last;
    // name, valid, rd, wr, f3, addr, wd, rdin, gnt_dly, rv_dly,
    // fault, stalls, daddr, be, wdata, rdata
    vecs[0]  = '{"sw", 1, 0, 1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 0, 0,
                 0, 2, 32'h0000_1004, 4'b1111, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{"sb", 1, 0, 1, 3'b000, 32'h0000_2003, 32'h0000_00A5, 32'h0, 0, 0,
                 0, 2, 32'h0000_2000, 4'b1000, 32'hA5A5_A5A5, 32'h0};
    vecs[2]  = '{"lb", 1, 1, 0, 3'b000, 32'h0000_3002, 32'h0, 32'h0080_0000, 2, 0,
                 0, 5, 32'h0000_3000, 4'b0100, 32'h0, 32'hFFFF_FF80};
    vecs[3]  = '{"lbu", 1, 1, 0, 3'b100, 32'h0000_3002, 32'h0, 32'h0080_0000, 2, 0,
                 0, 5, 32'h0000_3000, 4'b0100, 32'h0, 32'h0000_0080};
    vecs[4]  = '{"lh", 1, 1, 0, 3'b001, 32'h0000_4002, 32'h0, 32'h8001_1234, 0, 0,
                 0, 3, 32'h0000_4000, 4'b1100, 32'h0, 32'hFFFF_8001};
    vecs[5]  = '{"lhu_mis", 1, 1, 0, 3'b101, 32'h0000_4001, 32'h0, 32'h0, 0, 0,
                 1, 0, 32'h0, 4'b0000, 32'h0, 32'h0};
    vecs[6]  = '{"lw", 1, 1, 0, 3'b010, 32'h0000_5000, 32'h0, 32'h1234_5678, 1, 2,
                 0, 6, 32'h0000_5000, 4'b1111, 32'h0, 32'h1234_5678};
    vecs[7]  = '{"bubble", 0, 1, 0, 3'b010, 32'h0000_5000, 32'h0, 32'h0, 0, 0,
                 0, 0, 32'h0, 4'b0000, 32'h0, 32'h1234_5678};
    vecs[8]  = '{"f3_011", 1, 1, 0, 3'b011, 32'h0000_5000, 32'h0, 32'h0, 0, 0,
                 1, 0, 32'h0, 4'b0000, 32'h0, 32'h0};
    vecs[9]  = '{"sh", 1, 0, 1, 3'b001, 32'h0000_6002, 32'h0000_BEEF, 32'h0, 0, 0,
                 0, 2, 32'h0000_6000, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vecs[10] = '{"lhu", 1, 1, 0, 3'b101, 32'h0000_7000, 32'h0, 32'hABCD_F00D, 0, 0,
                 0, 3, 32'h0000_7000, 4'b0011, 32'h0, 32'h0000_F00D};
    vecs[11] = '{"st_f3_100", 1, 0, 1, 3'b100, 32'h0000_0100, 32'h0, 32'h0, 0, 0,
                 1, 0, 32'h0, 4'b0000, 32'h0, 32'h0};
    vecs[12] = '{"rd_wr_both", 1, 1, 1, 3'b010, 32'h0000_0000, 32'h0, 32'h0, 0, 0,
                 1, 0, 32'h0, 4'b0000, 32'h0, 32'h0};
    vecs[13] = '{"lw_mis", 1, 1, 0, 3'b010, 32'h0000_5002, 32'h0, 32'h0, 0, 0,
                 1, 0, 32'h0, 4'b0000, 32'h0, 32'h0};
    vecs[14] = '{"lb_lane1", 1, 1, 0, 3'b000, 32'h0000_7001, 32'h0, 32'h0000_FF00, 0, 1,
                 0, 4, 32'h0000_7000, 4'b0010, 32'h0, 32'hFFFF_FFFF};

    rst = 1'b1;
    DRData = '0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset dreq", 32'(DReq), 32'd0);
    chk("reset dwe", 32'(DWe), 32'd0);
    chk("reset daddr", DAddr, 32'h0);
    chk("reset byte_en", 32'(DByteEn), 32'd0);
    chk("reset wdata", DWData, 32'h0);
    chk("reset rdata", ReadDataM, 32'h0);
    chk("reset stall", 32'(StallM), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Async reset while a load waits for its response.
    @(negedge clk);
    ValidM = 1'b1; MemReadM = 1'b1; Funct3M = 3'b010; ALUResultM = 32'h0000_8000;
    DRData = 32'h5555_AAAA;
    @(posedge clk);
    @(negedge clk);
    DGnt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_inputs();
    #1;
    chk("wait_r stall", 32'(StallM), 32'd1);
    chk("wait_r daddr", DAddr, 32'h0000_8000);
    #1 rst = 1'b1;
    #1;
    chk("rst dreq", 32'(DReq), 32'd0);
    chk("rst daddr", DAddr, 32'h0);
    chk("rst byte_en", 32'(DByteEn), 32'd0);
    chk("rst rdata", ReadDataM, 32'h0);
    chk("rst stall", 32'(StallM), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    DRValid = 1'b1;
    @(negedge clk);
    DRValid = 1'b0;
    #1;
    chk("stray rvalid rdata", ReadDataM, 32'h0);
    chk("stray rvalid stall", 32'(StallM), 32'd0);

    last = '{"lw_after_rst", 1, 1, 0, 3'b010, 32'h0000_9000, 32'h0, 32'hCAFE_F00D, 0, 0,
             0, 3, 32'h0000_9000, 4'b1111, 32'h0, 32'hCAFE_F00D};
    run_vec(last);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
